// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: widths, decoded control bundle, bubble values, ALU op codes.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 15;

    localparam logic [1:0] WBI_NONE      = 2'b00;
    localparam logic [1:0] DATASIZE_NONE = 2'b11;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       is_jump;
        logic       is_not_cond;
        logic       is_eq;
        logic       mem_write;
        logic       is_load;
        logic [1:0] wbi;
        logic [1:0] datasize;
        logic       alu_src;
        logic       reg_dst;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{
        alu_op: 4'b0000, is_jump: 1'b0, is_not_cond: 1'b0, is_eq: 1'b0,
        mem_write: 1'b0, is_load: 1'b0, wbi: WBI_NONE, datasize: DATASIZE_NONE,
        alu_src: 1'b0, reg_dst: 1'b0
    };

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the instruction in ID.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_valid_i,
    input  logic             ex_is_load_i,
    input  logic [REG_W-1:0] ex_dst_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             id_valid_i,
    output logic             hazard_o
);

    // rt is compared for every opcode; a spurious stall is cheaper than decoding usage here.
    assign hazard_o = id_valid_i & ex_valid_i & ex_is_load_i & (ex_dst_i != '0)
                    & ((ex_dst_i == id_rs_i) | (ex_dst_i == id_rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and memory freeze.
// Optional hazard-bubble counter on stall_cnt_o when ID_EX_STALL_CNT_EN is defined.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_W  = mips_pkg::REG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [3:0]        id_aluOp,
    input  logic              id_isJump,
    input  logic              id_isNotConditional,
    input  logic              id_isEq,
    input  logic              id_memWrite,
    input  logic              id_isLoad,
    input  logic [1:0]        id_wbi,
    input  logic [1:0]        id_datasize,
    input  logic              id_aluSrc,
    input  logic              id_regDst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rdA,
    input  logic [DATA_W-1:0] id_rdB,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] id_pc4,
    input  logic              flush_i,
    input  logic              mem_stall_i,
    output logic              ex_valid,
    output logic [3:0]        ex_aluOp,
    output logic              ex_isJump,
    output logic              ex_isNotConditional,
    output logic              ex_isEq,
    output logic              ex_memWrite,
    output logic              ex_isLoad,
    output logic [1:0]        ex_wbi,
    output logic [1:0]        ex_datasize,
    output logic              ex_aluSrc,
    output logic              ex_regDst,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,
    output logic [DATA_W-1:0] ex_rdA,
    output logic [DATA_W-1:0] ex_rdB,
    output logic [DATA_W-1:0] ex_imm,
    output logic [DATA_W-1:0] ex_pc4,
    output logic [REG_W-1:0]  ex_dst,
`ifdef ID_EX_STALL_CNT_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              stall_o
);

    ctrl_t             ctrl_q, ctrl_d, id_ctrl;
    logic              valid_q, valid_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d, dst_q, dst_d;
    logic [DATA_W-1:0] rda_q, rda_d, rdb_q, rdb_d, imm_q, imm_d, pc4_q, pc4_d;
    logic              hazard;

    load_use_detect #(.REG_W(REG_W)) u_detect (
        .ex_valid_i   (valid_q),
        .ex_is_load_i (ctrl_q.is_load),
        .ex_dst_i     (dst_q),
        .id_rs_i      (id_rs),
        .id_rt_i      (id_rt),
        .id_valid_i   (id_valid),
        .hazard_o     (hazard)
    );

    assign stall_o = mem_stall_i | (hazard & ~flush_i);

    assign id_ctrl = '{
        alu_op: id_aluOp, is_jump: id_isJump, is_not_cond: id_isNotConditional,
        is_eq: id_isEq, mem_write: id_memWrite, is_load: id_isLoad, wbi: id_wbi,
        datasize: id_datasize, alu_src: id_aluSrc, reg_dst: id_regDst
    };

    always_comb begin
        // NOTE: every next-state signal defaults to its register so no path infers a latch.
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        dst_d   = dst_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        imm_d   = imm_q;
        pc4_d   = pc4_q;
        if (mem_stall_i) begin
            // freeze outranks flush; EX keeps flush asserted until the freeze lifts
        end else if (flush_i || hazard || !id_valid) begin
            ctrl_d  = CTRL_BUBBLE;
            valid_d = 1'b0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            dst_d   = '0;
            rda_d   = '0;
            rdb_d   = '0;
            imm_d   = '0;
            pc4_d   = '0;
        end else begin
            ctrl_d  = id_ctrl;
            valid_d = 1'b1;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            dst_d   = id_regDst ? id_rd : id_rt;
            rda_d   = id_rdA;
            rdb_d   = id_rdB;
            imm_d   = id_imm;
            pc4_d   = id_pc4;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q  <= CTRL_BUBBLE;
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            dst_q   <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            dst_q   <= dst_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
        end
    end

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!mem_stall_i && !flush_i && hazard && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign stall_cnt_o = cnt_q;
`endif

    assign ex_valid            = valid_q;
    assign ex_aluOp            = ctrl_q.alu_op;
    assign ex_isJump           = ctrl_q.is_jump;
    assign ex_isNotConditional = ctrl_q.is_not_cond;
    assign ex_isEq             = ctrl_q.is_eq;
    assign ex_memWrite         = ctrl_q.mem_write;
    assign ex_isLoad           = ctrl_q.is_load;
    assign ex_wbi              = ctrl_q.wbi;
    assign ex_datasize         = ctrl_q.datasize;
    assign ex_aluSrc           = ctrl_q.alu_src;
    assign ex_regDst           = ctrl_q.reg_dst;
    assign ex_rs               = rs_q;
    assign ex_rt               = rt_q;
    assign ex_rd               = rd_q;
    assign ex_rdA              = rda_q;
    assign ex_rdB              = rdb_q;
    assign ex_imm              = imm_q;
    assign ex_pc4              = pc4_q;
    assign ex_dst              = dst_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction steps push hand-computed EX state,
// a negedge monitor pops and compares.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_isJump, id_isNotConditional, id_isEq, id_memWrite, id_isLoad;
    logic        id_aluSrc, id_regDst, flush_i, mem_stall_i;
    logic [3:0]  id_aluOp;
    logic [1:0]  id_wbi, id_datasize;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdA, id_rdB, id_imm, id_pc4;
    logic        ex_valid, ex_isJump, ex_isNotConditional, ex_isEq, ex_memWrite, ex_isLoad;
    logic        ex_aluSrc, ex_regDst, stall_o;
    logic [3:0]  ex_aluOp;
    logic [1:0]  ex_wbi, ex_datasize;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_dst;
    logic [31:0] ex_rdA, ex_rdB, ex_imm, ex_pc4;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_aluOp(id_aluOp),
        .id_isJump(id_isJump), .id_isNotConditional(id_isNotConditional), .id_isEq(id_isEq),
        .id_memWrite(id_memWrite), .id_isLoad(id_isLoad), .id_wbi(id_wbi),
        .id_datasize(id_datasize), .id_aluSrc(id_aluSrc), .id_regDst(id_regDst),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rdA(id_rdA), .id_rdB(id_rdB),
        .id_imm(id_imm), .id_pc4(id_pc4), .flush_i(flush_i), .mem_stall_i(mem_stall_i),
        .ex_valid(ex_valid), .ex_aluOp(ex_aluOp), .ex_isJump(ex_isJump),
        .ex_isNotConditional(ex_isNotConditional), .ex_isEq(ex_isEq),
        .ex_memWrite(ex_memWrite), .ex_isLoad(ex_isLoad), .ex_wbi(ex_wbi),
        .ex_datasize(ex_datasize), .ex_aluSrc(ex_aluSrc), .ex_regDst(ex_regDst),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_rdA(ex_rdA), .ex_rdB(ex_rdB),
        .ex_imm(ex_imm), .ex_pc4(ex_pc4), .ex_dst(ex_dst),
`ifdef ID_EX_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .stall_o(stall_o)
    );

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [1:0]  wbi;
        logic [1:0]  ds;
        logic        ld;
        logic        mw;
        logic        j;
        logic        src;
        logic        rdst;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a;
    } ins_t;

    typedef struct {
        string       name;
        ins_t        ins;
        logic [4:0]  dst;
        logic        stall;
    } exp_t;

    exp_t sb_q[$];

    // v op wbi ds ld mw j src rdst rs rt rd a
    localparam ins_t BUB  = '{1'b0, 4'h0, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0};
    localparam ins_t NOP  = BUB;
    localparam ins_t RT   = '{1'b1, 4'h2, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd3, 5'd5,  32'h1111_0000};
    localparam ins_t LW8  = '{1'b1, 4'h2, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd8, 5'd0,  32'h2222_0000};
    localparam ins_t AD8  = '{1'b1, 4'h2, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 5'd4, 5'd9,  32'h3333_0000};
    localparam ins_t LW0  = '{1'b1, 4'h2, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2, 5'd0, 5'd0,  32'h4444_0000};
    localparam ins_t AD0  = '{1'b1, 4'h2, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd10, 32'h5555_0000};
    localparam ins_t SUB  = '{1'b1, 4'h6, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd6, 5'd7, 5'd12, 32'hAAAA_0000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input ins_t i, input logic fl, input logic ms);
        @(posedge clk);
        #1;
        id_valid = i.v;               id_aluOp = i.op;           id_wbi = i.wbi;
        id_datasize = i.ds;           id_isLoad = i.ld;          id_memWrite = i.mw;
        id_isJump = i.j;              id_isNotConditional = i.j; id_isEq = i.j;
        id_aluSrc = i.src;            id_regDst = i.rdst;
        id_rs = i.rs;                 id_rt = i.rt;              id_rd = i.rd;
        id_rdA = i.a;                 id_rdB = ~i.a;             id_imm = i.a + 32'd1;
        id_pc4 = i.a + 32'd4;
        flush_i = fl;                 mem_stall_i = ms;
    endtask

    // Expected EX contents resulting from the previous step, and stall_o for the inputs just driven.
    task automatic expect_ex(input string n, input ins_t i, input logic [4:0] dst, input logic st);
        exp_t e;
        e.name = n; e.ins = i; e.dst = dst; e.stall = st;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            logic [31:0] ea;
            e = sb_q.pop_front();
            ea = e.ins.a;
            check({e.name, ".valid"},  {31'd0, ex_valid},    {31'd0, e.ins.v});
            check({e.name, ".aluOp"},  {28'd0, ex_aluOp},    {28'd0, e.ins.op});
            check({e.name, ".wbi"},    {30'd0, ex_wbi},      {30'd0, e.ins.wbi});
            check({e.name, ".ds"},     {30'd0, ex_datasize}, {30'd0, e.ins.ds});
            check({e.name, ".isLoad"}, {31'd0, ex_isLoad},   {31'd0, e.ins.ld});
            check({e.name, ".memWr"},  {31'd0, ex_memWrite}, {31'd0, e.ins.mw});
            check({e.name, ".ctlJ"},   {29'd0, ex_isJump, ex_isNotConditional, ex_isEq},
                                       {29'd0, e.ins.j, e.ins.j, e.ins.j});
            check({e.name, ".src"},    {30'd0, ex_aluSrc, ex_regDst}, {30'd0, e.ins.src, e.ins.rdst});
            check({e.name, ".regs"},   {17'd0, ex_rs, ex_rt, ex_rd}, {17'd0, e.ins.rs, e.ins.rt, e.ins.rd});
            check({e.name, ".dst"},    {27'd0, ex_dst},      {27'd0, e.dst});
            check({e.name, ".rdA"},    ex_rdA, ea);
            check({e.name, ".rdB"},    ex_rdB, e.ins.v ? ~ea : 32'h0);
            check({e.name, ".imm"},    ex_imm, e.ins.v ? ea + 32'd1 : 32'h0);
            check({e.name, ".pc4"},    ex_pc4, e.ins.v ? ea + 32'd4 : 32'h0);
            check({e.name, ".stall"},  {31'd0, stall_o},     {31'd0, e.stall});
        end
    end

    initial begin
        reset = 1'b1;
        id_valid = 0; id_aluOp = 0; id_wbi = 0; id_datasize = 0; id_isLoad = 0; id_memWrite = 0;
        id_isJump = 0; id_isNotConditional = 0; id_isEq = 0; id_aluSrc = 0; id_regDst = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_rdA = 0; id_rdB = 0; id_imm = 0; id_pc4 = 0;
        flush_i = 0; mem_stall_i = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        drive(RT,  0, 0); expect_ex("idle",       BUB, 5'd0,  1'b0);
        drive(LW8, 0, 0); expect_ex("rtype",      RT,  5'd5,  1'b0);
        drive(AD8, 0, 0); expect_ex("lw8",        LW8, 5'd8,  1'b1);
        drive(AD8, 0, 0); expect_ex("hz_bubble",  BUB, 5'd0,  1'b0);
        drive(NOP, 0, 0); expect_ex("add_after",  AD8, 5'd9,  1'b0);
        drive(LW0, 0, 0); expect_ex("nop_bub",    BUB, 5'd0,  1'b0);
        drive(AD0, 0, 0); expect_ex("lw0",        LW0, 5'd0,  1'b0);
        drive(LW8, 0, 0); expect_ex("add0",       AD0, 5'd10, 1'b0);
        drive(AD8, 1, 0); expect_ex("hz_flush",   LW8, 5'd8,  1'b0);
        drive(SUB, 0, 0); expect_ex("flush_bub",  BUB, 5'd0,  1'b0);
        drive(SUB, 0, 1); expect_ex("sub_frz1",   SUB, 5'd12, 1'b1);
        drive(SUB, 0, 1); expect_ex("sub_frz2",   SUB, 5'd12, 1'b1);
        drive(RT,  1, 1); expect_ex("sub_frz3",   SUB, 5'd12, 1'b1);
        drive(RT,  0, 0); expect_ex("frz_held",   SUB, 5'd12, 1'b0);
        drive(NOP, 0, 0); expect_ex("resume",     RT,  5'd5,  1'b0);
        drive(RT,  0, 0); expect_ex("nop_bub2",   BUB, 5'd0,  1'b0);

        // Let the monitor drain before poking reset outside the scoreboard.
        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

`ifdef ID_EX_STALL_CNT_EN
        check("stall_cnt", {16'd0, stall_cnt_o}, 32'd1);
`endif

        // RT was driven last; it is captured at this edge, then reset lands mid-cycle.
        @(posedge clk);
        #1 check("pre_reset.valid", {31'd0, ex_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async_rst.valid", {31'd0, ex_valid},    32'd0);
        check("async_rst.ds",    {30'd0, ex_datasize}, 32'd3);
        check("async_rst.wbi",   {30'd0, ex_wbi},      32'd0);
        check("async_rst.dst",   {27'd0, ex_dst},      32'd0);
        check("async_rst.rdA",   ex_rdA,               32'd0);
`ifdef ID_EX_STALL_CNT_EN
        check("async_rst.cnt",   {16'd0, stall_cnt_o}, 32'd0);
`endif
        #2 reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the MIPS core; sits directly downstream of the opcode control decoder and register file.
- Latches the decoded control bundle, register indices, operands, immediate and PC+4 for the EX stage.
- Contains load-use hazard detection: inserts a one-cycle bubble and stalls PC/IF-ID.
- Honours branch flush from EX and a global memory freeze.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_W, 5, register index width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_aluOp  in  4  ALU op from decoder
- id_isJump, id_isNotConditional, id_isEq  in  1 each  branch/jump controls
- id_memWrite  in  1  store enable
- id_isLoad  in  1  opcode[5:3]==3'b100 (memory read)
- id_wbi  in  2  [1]=regWrite, [0]=1 ALU / 0 memory
- id_datasize  in  2  memory access size
- id_aluSrc, id_regDst  in  1 each  operand-B and destination select
- id_rs, id_rt, id_rd  in  REG_W  register indices
- id_rdA, id_rdB, id_imm, id_pc4  in  DATA_W each  operands, sign-extended immediate, PC+4
- flush_i  in  1  EX resolved taken branch/jump; kill ID/EX contents
- mem_stall_i  in  1  global freeze (memory not ready)
- ex_* outputs  out  same widths as id_* counterparts (incl. ex_isLoad, ex_valid)
- ex_dst  out  REG_W  resolved destination: regDst ? rd : rt
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)

Behaviour:
- Reset (async, any time incl. mid-stall): all ex_* = 0 except ex_datasize = 2'b11; ex_wbi = 2'b00; ex_valid = 0. Reset state is the bubble.
- Bubble = reset values: no regWrite, no memWrite, no jump, ex_valid = 0.
- hazard = id_valid & ex_valid & ex_isLoad & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt). Conservative: rt compared for every opcode.
- stall_o = mem_stall_i | (hazard & ~flush_i).
- Posedge update priority:
  1. mem_stall_i: hold all registers.
  2. flush_i: load bubble.
  3. hazard: load bubble; ID instruction is re-presented next cycle by upstream hold.
  4. Otherwise: capture all id_* and compute ex_dst; ex_valid = id_valid.
- If id_valid = 0 and no freeze, capture is replaced by a bubble.
- Latency: 1 cycle ID→EX.
- Hazard stall is exactly 1 cycle: after the bubble, ex_valid = 0, so hazard deasserts.
- flush_i together with hazard: flush wins, stall_o = 0; the killed ID instruction is discarded upstream.
- mem_stall_i together with flush_i: freeze wins; the flush must be held by EX until the freeze releases.
- ex_dst == 0 never triggers a hazard.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined: adds port stall_cnt_o, out, 16 bits. It increments on each posedge where a hazard bubble is inserted (rule 3 taken). It saturates at 16'hFFFF and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - DATA_W and REG_W defaults
  - control bundle width (15 bits incl. isLoad)
  - BUBBLE constants: WBI_NONE = 2'b00, DATASIZE_NONE = 2'b11
  - ALU op encodings shared with the decoder
- Natural sub-module: load_use_detect, purely combinational. Inputs: ex_valid, ex_isLoad, ex_dst, id_rs, id_rt, id_valid. Output: hazard.

Test Plan:
- Reset asserted mid-capture → all outputs take their bubble values immediately, with no clock edge: ex_datasize = 11, ex_wbi = 00, ex_valid = 0.
- R-type (aluOp 0010, wbi 11, regDst 1, rd = 5, rt = 3) → next cycle ex_dst = 5, ex_wbi = 11, ex_valid = 1, stall_o = 0.
- lw with rt = 8, followed by add with rs = 8 → stall_o = 1 for exactly one cycle; the bubble enters EX; the add reaches EX one cycle later; stall_cnt_o = 1 if enabled.
- lw with rt = 0, followed by an instruction with rs = 0 → no stall.
- Load-use hazard with flush_i = 1 in the same cycle → stall_o = 0, next ex_valid = 0, counter unchanged.
- mem_stall_i held for 3 cycles during a valid sub → ex_* unchanged and stall_o = 1 each cycle. After release, capture resumes; 65536 hazards saturate the counter at FFFF.
